// File: rtl/melody_sequencer.sv
// Song player: walks a {voice, duration} ROM, timing each note in beats with a
// trailing silent gap, and drives the voice code toward the note selector.
module melody_sequencer #(
   parameter int BEAT_DIV  = 10_000_000,
   parameter int GAP_CYC   = 400_000,
   parameter int SONG_LEN  = 32,
   parameter int TEST_SONG = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic       loop_en,
   output logic [3:0] voice,
   output logic [4:0] beat_idx,
   output logic       busy,
   output logic       done
);

   localparam int CNT_W = $clog2(BEAT_DIV * 7);

   typedef enum logic [2:0] {S_IDLE, S_PLAY, S_GAP, S_PAUSE, S_DONE} state_t;

   localparam logic [6:0] TEST_ROM [0:31] = '{
      0: {4'd1, 3'd2}, 1: {4'd5, 3'd1}, 2: {4'd0, 3'd1}, default: 7'd0
   };

   localparam logic [6:0] DEF_ROM [0:31] = '{
      0:  {4'd1, 3'd1},  1: {4'd1, 3'd1},  2: {4'd8, 3'd1},  3: {4'd8, 3'd1},
      4:  {4'd10, 3'd1}, 5: {4'd10, 3'd1}, 6: {4'd8, 3'd2},  7: {4'd6, 3'd1},
      8:  {4'd6, 3'd1},  9: {4'd5, 3'd1}, 10: {4'd5, 3'd1}, 11: {4'd3, 3'd1},
      12: {4'd3, 3'd1}, 13: {4'd1, 3'd2}, 14: {4'd0, 3'd2},
      default: 7'd0
   };

   function automatic logic [3:0] rom_voice(input logic [4:0] idx);
      return (TEST_SONG != 0) ? TEST_ROM[idx][6:3] : DEF_ROM[idx][6:3];
   endfunction

   function automatic logic [2:0] rom_dur(input logic [4:0] idx);
      return (TEST_SONG != 0) ? TEST_ROM[idx][2:0] : DEF_ROM[idx][2:0];
   endfunction

   state_t           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       voice_q, voice_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [2:0]       cur_dur, nxt_dur;
   logic [4:0]       nxt_idx;
   logic [CNT_W-1:0] play_end, note_end;
   logic             last_entry;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      cur_dur    = rom_dur(idx_q);
      nxt_idx    = idx_q + 5'd1;
      nxt_dur    = rom_dur(nxt_idx);
      play_end   = CNT_W'(int'(cur_dur) * BEAT_DIV - GAP_CYC - 1);
      note_end   = CNT_W'(int'(cur_dur) * BEAT_DIV - 1);
      last_entry = (idx_q == 5'(SONG_LEN - 1)) || (nxt_dur == 3'd0);

      if (stop) begin
         state_d = S_IDLE;
         idx_d   = 5'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // idx_q is always 0 here, so cur_dur is entry 0
               if (start) begin
                  cnt_d   = '0;
                  state_d = (cur_dur == 3'd0) ? S_DONE : S_PLAY;
               end
            end
            S_PLAY, S_GAP, S_PAUSE: begin
               // A paused note resumes as PLAY or GAP depending on where its counter sits;
               // the resume edge itself advances time like a normal playing cycle.
               if (pause) begin
                  state_d = S_PAUSE;
               end else if (cnt_q <= play_end) begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = (cnt_q == play_end) ? S_GAP : S_PLAY;
               end else if (cnt_q == note_end) begin
                  cnt_d = '0;
                  if (!last_entry) begin
                     idx_d   = nxt_idx;
                     state_d = S_PLAY;
                  end else begin
                     idx_d   = 5'd0;
                     state_d = loop_en ? S_PLAY : S_DONE;
                  end
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_GAP;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      voice_d = (state_d == S_PLAY) ? rom_voice(idx_d) : 4'd0;
      busy_d  = (state_d == S_PLAY) || (state_d == S_GAP) || (state_d == S_PAUSE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 5'd0;
         cnt_q   <= '0;
         voice_q <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         voice_q <= voice_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign voice    = voice_q;
   assign beat_idx = idx_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with the 4-entry test ROM: directed song timelines
// plus randomized control traffic against a note-time reference model.
module tb_melody_sequencer;
   localparam int BD = 4;
   localparam int GC = 1;
   localparam int SL = 32;

   logic       clk = 1'b0;
   logic       rst, start, stop, pause, loop_en;
   logic [3:0] voice;
   logic [4:0] beat_idx;
   logic       busy, done;

   int vectors     = 0;
   int miscompares = 0;

   melody_sequencer #(.BEAT_DIV(BD), .GAP_CYC(GC), .SONG_LEN(SL), .TEST_SONG(1)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .loop_en(loop_en), .voice(voice), .beat_idx(beat_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference song and model state: which note, how many cycles of it have elapsed.
   int song_voice [4] = '{1, 5, 0, 0};
   int song_dur   [4] = '{2, 1, 1, 0};
   bit m_active, m_paused, m_done;
   int m_entry, m_elapsed;
   logic [3:0] e_voice;
   logic [4:0] e_idx;
   logic       e_busy, e_done;

   function automatic int dur_of(input int i);
      return (i < 4) ? song_dur[i] : 0;
   endfunction

   task automatic model_outputs();
      int len = dur_of(m_entry) * BD;
      e_voice = (m_active && !m_paused && m_elapsed < len - GC) ? 4'(song_voice[m_entry]) : 4'd0;
      e_idx   = 5'(m_entry);
      e_busy  = m_active;
      e_done  = m_done;
   endtask

   task automatic model_reset();
      m_active = 0; m_paused = 0; m_done = 0; m_entry = 0; m_elapsed = 0;
      model_outputs();
   endtask

   task automatic model_step(input bit s, input bit st, input bit p, input bit l);
      if (st) begin
         m_active = 0; m_paused = 0; m_done = 0; m_entry = 0; m_elapsed = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_active) begin
         if (p) m_paused = 1;
         else begin
            m_paused = 0;
            m_elapsed++;
            if (m_elapsed == dur_of(m_entry) * BD) begin
               m_elapsed = 0;
               if (m_entry == SL - 1 || dur_of(m_entry + 1) == 0) begin
                  m_entry = 0;
                  if (!l) begin m_active = 0; m_done = 1; end
               end else m_entry++;
            end
         end
      end else if (s) begin
         m_entry = 0; m_elapsed = 0;
         if (dur_of(0) == 0) m_done = 1; else m_active = 1;
      end
      model_outputs();
   endtask

   task automatic drive(input bit s, input bit st, input bit p, input bit l);
      start = s; stop = st; pause = p; loop_en = l;
      @(posedge clk);
      model_step(s, st, p, l);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; start = 0; stop = 0; pause = 0; loop_en = 0;
      @(posedge clk); @(posedge clk); #1;
      model_reset();
      vectors++;
      if ({voice, beat_idx, busy, done} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset: voice=%0d idx=%0d busy=%b done=%b, want all 0", voice, beat_idx, busy, done);
      end
      rst = 0;
      drive(0, 0, 0, 0);
   endtask

   task automatic test_song();
      logic [3:0] ev;
      for (int k = 1; k <= 19; k++) begin
         drive(k == 1, 0, 0, 0);
         ev = (k <= 7) ? 4'd1 : (k >= 9 && k <= 11) ? 4'd5 : 4'd0;
         vectors++;
         if (voice !== ev || done !== (k == 17) || busy !== (k <= 16)) begin
            miscompares++;
            $display("FAIL song c%0d: voice=%0d busy=%b done=%b, want voice=%0d busy=%b done=%b",
                     k, voice, busy, done, ev, (k <= 16), (k == 17));
         end
         vectors++;
         if ({voice, beat_idx, busy, done} !== {e_voice, e_idx, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL song_model c%0d: voice=%0d idx=%0d busy=%b done=%b, want %0d %0d %b %b",
                     k, voice, beat_idx, busy, done, e_voice, e_idx, e_busy, e_done);
         end
      end
   endtask

   task automatic test_loop();
      for (int k = 1; k <= 22; k++) begin
         drive(k == 1, 0, 0, 1);
         vectors++;
         if ({voice, beat_idx, busy, done} !== {e_voice, e_idx, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL loop_model c%0d: voice=%0d idx=%0d busy=%b done=%b, want %0d %0d %b %b",
                     k, voice, beat_idx, busy, done, e_voice, e_idx, e_busy, e_done);
         end
         if (k == 17) begin
            vectors++;
            if (voice !== 4'd1 || beat_idx !== 5'd0 || done !== 1'b0 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL loop_restart: voice=%0d idx=%0d busy=%b done=%b, want 1 0 1 0",
                        voice, beat_idx, busy, done);
            end
         end
      end
      drive(0, 1, 0, 0);
      vectors++;
      if (busy !== 1'b0 || voice !== 4'd0) begin
         miscompares++;
         $display("FAIL loop_stop: busy=%b voice=%0d, want 0 0", busy, voice);
      end
   endtask

   task automatic test_pause();
      for (int k = 1; k <= 24; k++) begin
         drive(k == 1, 0, (k >= 3 && k <= 6), 0);
         vectors++;
         if ({voice, beat_idx, busy, done} !== {e_voice, e_idx, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL pause_model c%0d: voice=%0d idx=%0d busy=%b done=%b, want %0d %0d %b %b",
                     k, voice, beat_idx, busy, done, e_voice, e_idx, e_busy, e_done);
         end
         if ((k >= 3 && k <= 6) || k == 7 || k == 11 || k == 12 || k == 13) begin
            vectors++;
            if (voice !== ((k == 7 || k == 11) ? 4'd1 : (k == 13) ? 4'd5 : 4'd0) ||
                (k <= 6 && busy !== 1'b1)) begin
               miscompares++;
               $display("FAIL pause_timeline c%0d: voice=%0d busy=%b", k, voice, busy);
            end
         end
      end
   endtask

   task automatic test_stop();
      for (int k = 1; k <= 13; k++) begin
         drive(k == 1 || k == 5, k == 11, 0, 0);
         vectors++;
         if ({voice, beat_idx, busy, done} !== {e_voice, e_idx, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL stop_model c%0d: voice=%0d idx=%0d busy=%b done=%b, want %0d %0d %b %b",
                     k, voice, beat_idx, busy, done, e_voice, e_idx, e_busy, e_done);
         end
         if (k == 6) begin
            vectors++;
            if (voice !== 4'd1 || beat_idx !== 5'd0 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL start_ignored: voice=%0d idx=%0d busy=%b, want 1 0 1", voice, beat_idx, busy);
            end
         end
         if (k == 11) begin
            vectors++;
            if (voice !== 4'd0 || beat_idx !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL stop_abort: voice=%0d idx=%0d busy=%b done=%b, want 0 0 0 0",
                        voice, beat_idx, busy, done);
            end
         end
      end
   endtask

   task automatic test_start_stop();
      drive(1, 1, 0, 0);
      vectors++;
      if (busy !== 1'b0 || voice !== 4'd0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL start_stop: busy=%b voice=%0d done=%b, want 0 0 0", busy, voice, done);
      end
      drive(0, 0, 0, 0);
      vectors++;
      if (busy !== 1'b0 || voice !== 4'd0) begin
         miscompares++;
         $display("FAIL start_stop_after: busy=%b voice=%0d, want 0 0", busy, voice);
      end
   endtask

   task automatic test_random();
      bit l = 0;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(19) == 0) l = ~l;
         drive($urandom_range(7) == 0, $urandom_range(59) == 0, $urandom_range(5) == 0, l);
         vectors++;
         if ({voice, beat_idx, busy, done} !== {e_voice, e_idx, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL random c%0d: voice=%0d idx=%0d busy=%b done=%b, want %0d %0d %b %b",
                     k, voice, beat_idx, busy, done, e_voice, e_idx, e_busy, e_done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_song();
      test_loop();
      test_pause();
      test_stop();
      test_start_stop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
